pinmux_pad_filter_pes: RTL and testbench

Parametrised next-generation pinmux pad cell.
- Selects one of NUM_OUT_FUNC peripheral out/oe pairs onto the pad, with open-drain support.
- Input path: synchroniser, then glitch filter or debouncer, then fan-out to NUM_IN_FUNC peripheral inputs.
- Adds a port-error-stop (PES) state machine that forces the pad to a programmed safe state on enabled error sources.
- Sits between the peripheral function buses and the pad I/O ring, one instance per pin.

---
 rtl/pinmux_pkg.sv | 26 ++
 rtl/pinmux_in_filter.sv | 104 ++++++++++
 rtl/pinmux_pad_filter_pes.sv | 135 +++++++++++++
 tb/tb_pinmux_pad_filter_pes.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pinmux_pkg.sv
// Shared encodings for the pinmux pad cell: filter modes, PES safe values and
// the port-error-stop state enum.
package pinmux_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        FILT_BYPASS   = 2'b00,
        FILT_SYNC     = 2'b01,
        FILT_GLITCH   = 2'b10,
        FILT_DEBOUNCE = 2'b11
    } filt_mode_e;

    typedef enum logic [1:0] {
        SAFE_HIZ    = 2'b00,
        SAFE_DRIVE0 = 2'b01,
        SAFE_DRIVE1 = 2'b10,
        SAFE_HOLD   = 2'b11
    } safe_val_e;

    typedef enum logic {
        PES_RUN  = 1'b0,
        PES_STOP = 1'b1
    } pes_state_e;

endpackage

// File: rtl/pinmux_in_filter.sv
// Pad input path: synchroniser, glitch/debounce counter, filtered value and a
// one-cycle pulse whenever the filtered value changes.
module pinmux_in_filter
    import pinmux_pkg::*;
#(
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int FILT_CNT_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_in,
    input  logic [1:0]                i_mode,
    input  logic [FILT_CNT_WIDTH-1:0] i_thresh,
    input  logic                      i_tick,
    output logic                      o_filtered,
    output logic                      o_edge
);

    localparam logic [FILT_CNT_WIDTH:0] ONE = {{FILT_CNT_WIDTH{1'b0}}, 1'b1};

    filt_mode_e                mode;
    filt_mode_e                mode_q;
    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    logic [FILT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      filt_q, filt_d;
    logic                      prev_q, prev_d;
    logic                      edge_q, edge_d;
    logic                      sync;
    logic                      filtered;
    logic [FILT_CNT_WIDTH:0]   cnt_inc;
    logic [FILT_CNT_WIDTH:0]   thresh_eff;

    assign mode       = filt_mode_e'(i_mode);
    assign sync       = sync_q[SYNC_STAGES-1];
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], i_in};
    assign cnt_inc    = {1'b0, cnt_q} + ONE;
    // A threshold of zero behaves like one: a single qualifying cycle suffices.
    assign thresh_eff = (i_thresh == '0) ? ONE : {1'b0, i_thresh};

    always_comb begin
        case (mode)
            FILT_BYPASS: filtered = i_in;
            FILT_SYNC:   filtered = sync;
            default:     filtered = filt_q;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        case (mode)
            FILT_BYPASS: begin
                filt_d = i_in;
                cnt_d  = '0;
            end
            FILT_SYNC: begin
                filt_d = sync;
                cnt_d  = '0;
            end
            default: begin
                if (sync == filt_q) begin
                    cnt_d = '0;
                end else if (mode == FILT_GLITCH || i_tick) begin
                    if (cnt_inc >= thresh_eff) begin
                        filt_d = sync;
                        cnt_d  = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_inc[FILT_CNT_WIDTH-1:0];
                    end
                end
            end
        endcase
        // A mode switch restarts qualification but keeps the filtered value.
        if (mode != mode_q) begin
            cnt_d = '0;
            if (mode == FILT_GLITCH || mode == FILT_DEBOUNCE) filt_d = filt_q;
        end
    end

    assign prev_d = filtered;
    assign edge_d = filtered ^ prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
            mode_q <= FILT_BYPASS;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            mode_q <= mode;
        end
    end

    assign o_filtered = filtered;
    assign o_edge     = edge_q;

endmodule

// File: rtl/pinmux_pad_filter_pes.sv
// Pinmux pad cell: output function select with open-drain, filtered input
// fan-out, and a port-error-stop machine that parks the pad in a safe state.
module pinmux_pad_filter_pes
    import pinmux_pkg::*;
#(
    parameter int NUM_OUT_FUNC   = 8,
    parameter int NUM_IN_FUNC    = 8,
    parameter int SEL_WIDTH      = 5,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int FILT_CNT_WIDTH = 8,
    parameter int NUM_PES_SRC    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [SEL_WIDTH-1:0]      i_outfunc_sel,
    input  logic [NUM_OUT_FUNC-1:0]   i_peripheral_out,
    input  logic [NUM_OUT_FUNC-1:0]   i_peripheral_oe,
    input  logic [NUM_IN_FUNC-1:0]    i_infunc_en,
    output logic [NUM_IN_FUNC-1:0]    o_peripheral_in,
    input  logic                      i_pinctlx_od,
    input  logic                      i_pinctlx_ie,
    input  logic                      i_gpioquten,
    input  logic [1:0]                i_filt_mode,
    input  logic [FILT_CNT_WIDTH-1:0] i_filt_thresh,
    input  logic                      i_debounce_tick,
    input  logic [NUM_PES_SRC-1:0]    i_pes_en,
    input  logic [NUM_PES_SRC-1:0]    i_pes_err,
    input  logic [1:0]                i_pes_safeval,
    input  logic                      i_pes_release,
    output logic                      o_pes_active,
    input  logic                      i_pad_in,
    output logic                      o_pad_out,
    output logic                      o_pad_oe,
    output logic                      o_gpio_in,
    output logic                      o_filt_edge
);

    pes_state_e state_q, state_d;
    logic       pad_out_q, pad_out_d;
    logic       pad_oe_q, pad_oe_d;
    logic       hold_out_q, hold_out_d;
    logic       hold_oe_q, hold_oe_d;
    logic       pes_active_q, pes_active_d;
    logic       out_sel, oe_sel;
    logic       run_out, run_oe;
    logic       hit;
    logic       filtered;

    always_comb begin
        out_sel = 1'b0;
        oe_sel  = 1'b0;
        for (int i = 0; i < NUM_OUT_FUNC; i++) begin
            if (i_outfunc_sel == SEL_WIDTH'(i)) begin
                out_sel = i_peripheral_out[i];
                oe_sel  = i_peripheral_oe[i];
            end
        end
    end

    // Open-drain only ever pulls low: driving "1" means releasing the pad.
    assign run_out = i_pinctlx_od ? 1'b0 : out_sel;
    assign run_oe  = (i_pinctlx_od ? ~out_sel : oe_sel) & i_gpioquten;
    assign hit     = |(i_pes_en & i_pes_err);

    always_comb begin
        state_d    = state_q;
        hold_out_d = hold_out_q;
        hold_oe_d  = hold_oe_q;
        case (state_q)
            PES_RUN: begin
                if (hit) begin
                    state_d    = PES_STOP;
                    hold_out_d = pad_out_q;
                    hold_oe_d  = pad_oe_q;
                end
            end
            PES_STOP: begin
                if (i_pes_release && !hit) state_d = PES_RUN;
            end
            default: state_d = PES_RUN;
        endcase

        // Safe value takes effect on the same edge that enters STOP.
        pad_out_d = run_out;
        pad_oe_d  = run_oe;
        if (state_d == PES_STOP) begin
            case (safe_val_e'(i_pes_safeval))
                SAFE_HIZ:    begin pad_out_d = 1'b0;       pad_oe_d = 1'b0;      end
                SAFE_DRIVE0: begin pad_out_d = 1'b0;       pad_oe_d = 1'b1;      end
                SAFE_DRIVE1: begin pad_out_d = 1'b1;       pad_oe_d = 1'b1;      end
                default:     begin pad_out_d = hold_out_d; pad_oe_d = hold_oe_d; end
            endcase
        end
        pes_active_d = (state_d == PES_STOP);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= PES_RUN;
            pad_out_q    <= 1'b0;
            pad_oe_q     <= 1'b0;
            hold_out_q   <= 1'b0;
            hold_oe_q    <= 1'b0;
            pes_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pad_out_q    <= pad_out_d;
            pad_oe_q     <= pad_oe_d;
            hold_out_q   <= hold_out_d;
            hold_oe_q    <= hold_oe_d;
            pes_active_q <= pes_active_d;
        end
    end

    pinmux_in_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILT_CNT_WIDTH(FILT_CNT_WIDTH)
    ) u_in_filter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_in      (i_pad_in & i_pinctlx_ie),
        .i_mode    (i_filt_mode),
        .i_thresh  (i_filt_thresh),
        .i_tick    (i_debounce_tick),
        .o_filtered(filtered),
        .o_edge    (o_filt_edge)
    );

    assign o_pad_out       = pad_out_q;
    assign o_pad_oe        = pad_oe_q;
    assign o_pes_active    = pes_active_q;
    assign o_gpio_in       = filtered;
    assign o_peripheral_in = {NUM_IN_FUNC{filtered}} & i_infunc_en;

endmodule

// File: tb/tb_pinmux_pad_filter_pes.sv
// Scoreboard bench for the pinmux pad cell: directed scenarios then random
// traffic, each cycle checked against a behavioural model of the pin.
module tb_pinmux_pad_filter_pes;

    localparam int NO = 8, NI = 8, SW = 5, SS = 2, CW = 8, NP = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [SW-1:0] i_outfunc_sel;
    logic [NO-1:0] i_peripheral_out, i_peripheral_oe;
    logic [NI-1:0] i_infunc_en, o_peripheral_in;
    logic          i_pinctlx_od, i_pinctlx_ie, i_gpioquten;
    logic [1:0]    i_filt_mode;
    logic [CW-1:0] i_filt_thresh;
    logic          i_debounce_tick;
    logic [NP-1:0] i_pes_en, i_pes_err;
    logic [1:0]    i_pes_safeval;
    logic          i_pes_release, o_pes_active;
    logic          i_pad_in, o_pad_out, o_pad_oe, o_gpio_in, o_filt_edge;

    int n_cmp = 0;
    int n_bad = 0;

    // {pad_out, pad_oe, pes_active, gpio_in, filt_edge, peripheral_in}
    logic [12:0] exp_q[$];

    // Behavioural model of the pin
    bit m_sync[$];
    bit m_filt, m_prev, m_edge, m_stop, m_pout, m_poe, m_hout, m_hoe;
    int m_cnt;
    logic [1:0] m_mode;

    pinmux_pad_filter_pes #(
        .NUM_OUT_FUNC(NO), .NUM_IN_FUNC(NI), .SEL_WIDTH(SW),
        .SYNC_STAGES(SS), .FILT_CNT_WIDTH(CW), .NUM_PES_SRC(NP)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_outfunc_sel(i_outfunc_sel),
        .i_peripheral_out(i_peripheral_out), .i_peripheral_oe(i_peripheral_oe),
        .i_infunc_en(i_infunc_en), .o_peripheral_in(o_peripheral_in),
        .i_pinctlx_od(i_pinctlx_od), .i_pinctlx_ie(i_pinctlx_ie),
        .i_gpioquten(i_gpioquten),
        .i_filt_mode(i_filt_mode), .i_filt_thresh(i_filt_thresh),
        .i_debounce_tick(i_debounce_tick),
        .i_pes_en(i_pes_en), .i_pes_err(i_pes_err),
        .i_pes_safeval(i_pes_safeval), .i_pes_release(i_pes_release),
        .o_pes_active(o_pes_active),
        .i_pad_in(i_pad_in), .o_pad_out(o_pad_out), .o_pad_oe(o_pad_oe),
        .o_gpio_in(o_gpio_in), .o_filt_edge(o_filt_edge)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = {};
        for (int k = 0; k < SS; k++) m_sync.push_back(1'b0);
        m_filt = 0; m_prev = 0; m_edge = 0; m_stop = 0;
        m_pout = 0; m_poe = 0; m_hout = 0; m_hoe = 0;
        m_cnt = 0; m_mode = 2'b00;
    endtask

    // Advance the model by one clock with the inputs currently applied.
    task automatic model_step();
        bit pin, s_old, f_now, f_after, o, e, hit;
        int thr, s;
        pin   = i_pad_in & i_pinctlx_ie;
        s_old = m_sync[SS-1];
        f_now = (i_filt_mode == 0) ? pin : (i_filt_mode == 1) ? s_old : m_filt;
        m_edge = f_now ^ m_prev;
        m_prev = f_now;
        thr = (i_filt_thresh == 0) ? 1 : int'(i_filt_thresh);
        if (i_filt_mode != m_mode) begin
            m_cnt = 0;
            if (i_filt_mode < 2) m_filt = f_now;
        end else if (i_filt_mode < 2) begin
            m_filt = f_now;
            m_cnt = 0;
        end else if (s_old == m_filt) begin
            m_cnt = 0;
        end else if (i_filt_mode == 2 || i_debounce_tick) begin
            if (m_cnt + 1 >= thr) begin
                m_filt = s_old;
                m_cnt = 0;
            end else if (m_cnt < 255) begin
                m_cnt++;
            end
        end
        m_mode = i_filt_mode;
        m_sync.push_front(pin);
        void'(m_sync.pop_back());
        f_after = (i_filt_mode == 0) ? pin : (i_filt_mode == 1) ? m_sync[SS-1] : m_filt;

        s = int'(i_outfunc_sel);
        o = (s < NO) ? i_peripheral_out[s] : 1'b0;
        e = (s < NO) ? i_peripheral_oe[s] : 1'b0;
        if (i_pinctlx_od) begin
            e = ~o;
            o = 1'b0;
        end
        e = e & i_gpioquten;
        hit = |(i_pes_en & i_pes_err);
        if (!m_stop) begin
            if (hit) begin
                m_stop = 1; m_hout = m_pout; m_hoe = m_poe;
            end
        end else if (i_pes_release && !hit) begin
            m_stop = 0;
        end
        if (m_stop) begin
            case (i_pes_safeval)
                2'b00:   begin m_pout = 0;      m_poe = 0;     end
                2'b01:   begin m_pout = 0;      m_poe = 1;     end
                2'b10:   begin m_pout = 1;      m_poe = 1;     end
                default: begin m_pout = m_hout; m_poe = m_hoe; end
            endcase
        end else begin
            m_pout = o; m_poe = e;
        end
        exp_q.push_back({m_pout, m_poe, m_stop, f_after, m_edge, {NI{f_after}} & i_infunc_en});
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(negedge i_clk);
        end
    endtask

    // Called just after a falling edge; asserts reset between edges.
    task automatic apply_reset();
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_pad_oe", o_pad_oe, 0);
        chk("rst_pad_out", o_pad_out, 0);
        chk("rst_pes_active", o_pes_active, 0);
        chk("rst_filt_edge", o_filt_edge, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        model_reset();
        i_rst_n = 1'b1;
    endtask

    always @(posedge i_clk) begin
        logic [12:0] e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {o_pad_out, o_pad_oe, o_pes_active, o_gpio_in, o_filt_edge, o_peripheral_in};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    initial begin
        i_rst_n = 1'b1;
        i_outfunc_sel = 5'd3; i_peripheral_out = 8'h08; i_peripheral_oe = 8'h08;
        i_infunc_en = 8'hA5; i_pinctlx_od = 0; i_pinctlx_ie = 1; i_gpioquten = 1;
        i_filt_mode = 2'b00; i_filt_thresh = 8'd4; i_debounce_tick = 0;
        i_pes_en = 8'h04; i_pes_err = 8'h00; i_pes_safeval = 2'b10; i_pes_release = 0;
        i_pad_in = 0;
        model_reset();
        #1 i_rst_n = 1'b0;
        #2;
        chk("rst_pad_oe", o_pad_oe, 0);
        chk("rst_pad_out", o_pad_out, 0);
        chk("rst_pes_active", o_pes_active, 0);
        chk("rst_filt_edge", o_filt_edge, 0);
        @(negedge i_clk);
        chk("rst_hold_pad_oe", o_pad_oe, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Function select and out-of-range select
        run(2);
        i_outfunc_sel = 5'd9; run(2);
        i_outfunc_sel = 5'd3;

        // Open drain
        i_pinctlx_od = 1; run(2);
        i_peripheral_out = 8'h00; run(2);
        i_pinctlx_od = 0;

        // Glitch filter: short pulse rejected, long pulse accepted
        i_filt_mode = 2'b10; i_filt_thresh = 8'd4;
        run(4);
        i_pad_in = 1; run(3);
        i_pad_in = 0; run(8);
        i_pad_in = 1; run(10);
        i_pad_in = 0; run(10);

        // Debounce with prescaled tick
        i_filt_mode = 2'b11; i_filt_thresh = 8'd2; i_pad_in = 1;
        for (int k = 0; k < 40; k++) begin
            i_debounce_tick = (k % 8 == 7); run(1);
        end
        i_filt_thresh = 8'd0; i_pad_in = 0;
        for (int k = 0; k < 20; k++) begin
            i_debounce_tick = (k % 8 == 7); run(1);
        end
        i_debounce_tick = 0;

        // Port error stop, drive-1 safe value
        i_peripheral_out = 8'h08; i_peripheral_oe = 8'h08; i_pes_safeval = 2'b10;
        i_peripheral_out = 8'h00; run(2);
        i_pes_err = 8'h04; run(1);
        i_pes_err = 8'h00; run(3);
        i_pes_err = 8'h04; i_pes_release = 1; run(1);
        i_pes_err = 8'h00; i_pes_release = 0; run(2);
        i_pes_release = 1; run(1);
        i_pes_release = 0; run(2);

        // Hold-last safe value, then async reset while stopped
        i_pes_safeval = 2'b11; run(2);
        i_pes_err = 8'h04; run(1);
        i_pes_err = 8'h00; i_outfunc_sel = 5'd5; i_peripheral_out = 8'hFF; run(3);
        apply_reset();
        run(3);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            i_outfunc_sel    = SW'($urandom_range(0, 11));
            i_peripheral_out = NO'($urandom);
            i_peripheral_oe  = NO'($urandom);
            i_infunc_en      = NI'($urandom);
            i_pinctlx_od     = ($urandom_range(0, 3) == 0);
            i_pinctlx_ie     = ($urandom_range(0, 9) != 0);
            i_gpioquten      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) i_filt_mode = 2'($urandom);
            i_filt_thresh    = CW'($urandom_range(0, 5));
            i_debounce_tick  = ($urandom_range(0, 2) == 0);
            i_pes_en         = NP'($urandom);
            i_pes_err        = ($urandom_range(0, 24) == 0) ? NP'($urandom) : '0;
            i_pes_release    = ($urandom_range(0, 5) == 0);
            i_pes_safeval    = 2'($urandom);
            if ($urandom_range(0, 3) == 0) i_pad_in = ~i_pad_in;
            run(1);
        end
        apply_reset();
        run(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
